meduram_read_client: RTL and testbench
======================================

Name: meduram_read_client

Overview:
- Initiator-side front end for one meduram read port. Accepts single-word read requests from a client over a valid/ready handshake and drives rden/rdaddr into the RAM.
- Samples rddata and rdcollision after the RAM read latency. Retries reads that report a read collision, with an agent-specific backoff.
- Returns data plus collision status over a valid/ready response channel.
- One instance per read agent, placed between client logic and the meduram top.

Parameters:
- ADDR_WIDTH, 3, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- RD_LATENCY, 1, cycles from the rden cycle to valid rddata/rdcollision (range 1..4).
- AGENT_ID, 0, read agent index (0..3). Backoff length is AGENT_ID+1 cycles.
- MAX_RETRY, 3, retries allowed after the first attempt before giving up.
- CNT_WIDTH, 16, width of the collision statistics counter.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous active-high reset.
- req_valid  in  1  client read request.
- req_ready  out  1  request accepted when req_valid and req_ready are both high.
- req_addr  in  ADDR_WIDTH  read address.
- rden  out  1  RAM read enable.
- rdaddr  out  ADDR_WIDTH  RAM read address.
- rddata  in  DATA_WIDTH  RAM read data.
- rdcollision  in  2  RAM status: bit0 = write collision on the word, bit1 = read collision.
- resp_valid  out  1  response available.
- resp_ready  in  1  client accepts the response.
- resp_data  out  DATA_WIDTH  read data.
- resp_wrcoll  out  1  word was last written under a write collision.
- resp_err  out  1  retries exhausted; resp_data is not trusted.
- coll_count  out  CNT_WIDTH  saturating count of read collisions seen.

Behaviour:
- Reset: asynchronous on areset high. All outputs go to 0; FSM goes to IDLE; retry and latency counters clear; coll_count clears.
- FSM states: IDLE, ISSUE, WAIT, BACKOFF, RESP.
- IDLE:
  - req_ready=1.
  - On handshake: latch req_addr, set retry=0, go to ISSUE.
  - req_ready is 0 in every other state; there is only one outstanding request.
- ISSUE:
  - rden=1 and rdaddr=latched address for exactly one cycle.
  - Load lat=RD_LATENCY, go to WAIT.
  - rdaddr holds its last value when rden=0.
- WAIT:
  - Decrement lat each cycle.
  - On the cycle where lat reaches the final count, sample rddata/rdcollision; this is RD_LATENCY cycles after the ISSUE cycle.
  - rdcollision[1]=0: register data and wrcoll=rdcollision[0], err=0, go to RESP.
  - rdcollision[1]=1 and retry<MAX_RETRY: retry++, coll_count++ (saturating), load backoff=AGENT_ID+1, go to BACKOFF.
  - rdcollision[1]=1 and retry==MAX_RETRY: coll_count++, register data, err=1, wrcoll=rdcollision[0], go to RESP.
- BACKOFF: count down backoff cycles with rden=0, then go to ISSUE.
- RESP:
  - resp_valid=1; resp_* are stable while resp_valid=1 and resp_ready=0.
  - On handshake go to IDLE. req_ready rises the cycle after the handshake; there is no combinational ready path.
- Minimum request-to-response latency: 2+RD_LATENCY cycles, measured from the handshake edge to resp_valid high.
- coll_count sticks at all-ones and does not wrap.
- A request in flight when areset asserts is dropped silently with no response.
- RAM outputs are ignored outside the sample cycle.

Decomposition:
- Shared package meduram_pkg: FSM state enum, rdcollision bit indices (RDCOLL_WR=0, RDCOLL_RD=1), and the shared saturating-increment function.
- One natural sub-module, meduram_lat_timer: a loadable down-counter used by WAIT and BACKOFF, with load value and done pulse.
- All other logic lives in a single FSM.

Test Plan:
- Preload addr 5=0xA3 in the RAM model, RD_LATENCY=1; request addr 5 with resp_ready=1 -> rden one cycle with rdaddr=5; resp_valid 3 cycles after the handshake; resp_data=0xA3, wrcoll=0, err=0, coll_count=0.
- RAM model returns rdcollision=2 on the first attempt and 0 on the second; AGENT_ID=1 -> second rden exactly 1+RD_LATENCY+2 cycles after the first; correct data returned; coll_count=1.
- rdcollision=2 on every attempt, MAX_RETRY=3 -> 4 rden pulses, resp_err=1, coll_count=4.
- rdcollision=1 on addr 2 holding 0x5C -> resp_data=0x5C, wrcoll=1, err=0, no retry, coll_count=0.
- Hold resp_ready=0 for 5 cycles -> resp_valid/resp_data stable throughout; req_ready=0; a new req_valid is not accepted until the cycle after the response handshake.
- Assert areset during WAIT -> all outputs 0 immediately (asynchronously); no resp_valid; next request completes normally.

Source files
------------

// File: rtl/meduram_pkg.sv
// Shared definitions for the meduram read client: FSM states, rdcollision bit
// positions and the saturating counter increment.
package meduram_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StBackoff,
        StResp
    } rd_state_t;

    localparam int unsigned RDCOLL_WR = 0;
    localparam int unsigned RDCOLL_RD = 1;

    // Increment a counter of the given width, sticking at all-ones.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/meduram_lat_timer.sv
// Loadable down-counter; done is high in the last cycle of a loaded interval,
// so an interval of N cycles is obtained by loading N.
module meduram_lat_timer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == WIDTH'(1));

endmodule

// File: rtl/meduram_read_client.sv
// Read-port front end for one meduram agent: issues single-word reads, retries
// on read collisions with an agent-specific backoff, and returns data plus status.
module meduram_read_client
    import meduram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned AGENT_ID   = 0,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rden,
    output logic [ADDR_WIDTH-1:0] rdaddr,
    input  logic [DATA_WIDTH-1:0] rddata,
    input  logic [1:0]            rdcollision,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_wrcoll,
    output logic                  resp_err,
    output logic [CNT_WIDTH-1:0]  coll_count
);

    localparam int unsigned RW = $clog2(MAX_RETRY + 2);
    localparam int unsigned TW = 3;
    localparam logic [TW-1:0] LAT_LOAD     = TW'(RD_LATENCY);
    localparam logic [TW-1:0] BACKOFF_LOAD = TW'(AGENT_ID + 1);

    rd_state_t     state;
    logic [RW-1:0] retry;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;
    logic          coll_rd;
    logic          can_retry;

    assign coll_rd   = rdcollision[RDCOLL_RD];
    assign can_retry = (retry < RW'(MAX_RETRY));

    // WAIT interval is loaded during ISSUE; backoff is loaded on a retryable sample.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = LAT_LOAD;
        if (state == StIssue) begin
            tmr_load = 1'b1;
        end else if (state == StWait && tmr_done && coll_rd && can_retry) begin
            tmr_load = 1'b1;
            tmr_val  = BACKOFF_LOAD;
        end
    end

    meduram_lat_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk     (aclk),
        .rst     (areset),
        .load    (tmr_load),
        .load_val(tmr_val),
        .done    (tmr_done)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= StIdle;
            retry       <= '0;
            req_ready   <= 1'b0;
            rden        <= 1'b0;
            rdaddr      <= '0;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_wrcoll <= 1'b0;
            resp_err    <= 1'b0;
            coll_count  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        rdaddr    <= req_addr;
                        rden      <= 1'b1;
                        retry     <= '0;
                        state     <= StIssue;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                StIssue: begin
                    rden  <= 1'b0;
                    state <= StWait;
                end
                StWait: begin
                    if (tmr_done) begin
                        if (coll_rd) begin
                            coll_count <= CNT_WIDTH'(sat_inc(32'(coll_count), CNT_WIDTH));
                        end
                        if (coll_rd && can_retry) begin
                            retry <= retry + 1'b1;
                            state <= StBackoff;
                        end else begin
                            resp_valid  <= 1'b1;
                            resp_data   <= rddata;
                            resp_wrcoll <= rdcollision[RDCOLL_WR];
                            resp_err    <= coll_rd;
                            state       <= StResp;
                        end
                    end
                end
                StBackoff: begin
                    if (tmr_done) begin
                        rden  <= 1'b1;
                        state <= StIssue;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_meduram_read_client.sv
// Randomized bench for meduram_read_client against a RAM model and a
// transaction-level expectation model.
module tb_meduram_read_client;

    localparam int L  = 1;
    localparam int A  = 1;
    localparam int MR = 3;
    localparam int SPACING = 1 + L + A + 1;

    logic        aclk = 1'b0;
    logic        areset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_addr;
    logic        rden;
    logic [2:0]  rdaddr;
    logic [7:0]  rddata;
    logic [1:0]  rdcollision;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  resp_data;
    logic        resp_wrcoll;
    logic        resp_err;
    logic [15:0] coll_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_coll = 0;

    logic [7:0] mem [8];
    logic [1:0] plan [$];
    logic       pv [L];
    logic [7:0] pd [L];
    logic [1:0] pc [L];
    logic [7:0] junk_d;
    logic [1:0] junk_c;

    meduram_read_client #(
        .ADDR_WIDTH(3),
        .DATA_WIDTH(8),
        .RD_LATENCY(L),
        .AGENT_ID  (A),
        .MAX_RETRY (MR),
        .CNT_WIDTH (16)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .rden       (rden),
        .rdaddr     (rdaddr),
        .rddata     (rddata),
        .rdcollision(rdcollision),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_wrcoll(resp_wrcoll),
        .resp_err   (resp_err),
        .coll_count (coll_count)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    // RAM model: each read's data/status appears L cycles after its rden cycle;
    // outside that window the outputs carry random junk.
    always @(posedge aclk) begin
        junk_d <= 8'($urandom);
        junk_c <= 2'($urandom);
        for (int i = 1; i < L; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
            pc[i] <= pc[i-1];
        end
        pv[0] <= rden;
        pd[0] <= mem[rdaddr];
        if (rden && plan.size() != 0) begin
            pc[0] <= plan[0];
            void'(plan.pop_front());
        end else begin
            pc[0] <= 2'b00;
        end
    end

    assign rddata      = pv[L-1] ? pd[L-1] : junk_d;
    assign rdcollision = pv[L-1] ? pc[L-1] : junk_c;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge aclk);
    endtask

    // One request; plan must already hold the per-attempt rdcollision codes.
    task automatic run_txn(input logic [2:0] addr, input int hold);
        logic [1:0] p [$];
        logic [1:0] c;
        int att, hs, first, resp_cyc, nrd, n;
        logic exp_err, exp_wc;
        p = plan;
        att = 0;
        c = 2'b00;
        forever begin
            c = (att < p.size()) ? p[att] : 2'b00;
            att++;
            if (c[1]) exp_coll++;
            if (!c[1] || att == MR + 1) break;
        end
        exp_err = c[1];
        exp_wc  = c[0];

        resp_ready = (hold == 0);
        req_addr   = addr;
        req_valid  = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        check_eq("req_accept", req_ready, 1);
        hs = cyc;
        step();
        req_valid = 1'b0;

        nrd = 0;
        first = -1;
        n = 0;
        while (!resp_valid && n < 100) begin
            if (rden) begin
                if (nrd == 0) first = cyc;
                else check_eq("retry_spacing", cyc - first - nrd * SPACING, 0);
                nrd++;
                check_eq("rdaddr", rdaddr, addr);
            end
            step();
            n++;
        end
        check_eq("resp_timeout", resp_valid, 1);
        resp_cyc = cyc;
        check_eq("first_rden_cyc", first, hs + 1);
        check_eq("resp_latency", resp_cyc - hs, 2 + L + (att - 1) * SPACING);
        check_eq("rden_pulses", nrd, att);
        check_eq("resp_data", resp_data, mem[addr]);
        check_eq("resp_wrcoll", resp_wrcoll, exp_wc);
        check_eq("resp_err", resp_err, exp_err);
        check_eq("coll_count", coll_count, exp_coll);

        if (hold > 0) begin
            req_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                step();
                check_eq("hold_valid", resp_valid, 1);
                check_eq("hold_data", resp_data, mem[addr]);
                check_eq("hold_err", resp_err, exp_err);
                check_eq("hold_req_ready", req_ready, 0);
            end
            resp_ready = 1'b1;
        end
        step();
        req_valid = 1'b0;
        check_eq("idle_req_ready", req_ready, 1);
        check_eq("idle_resp_valid", resp_valid, 0);
        plan.delete();
    endtask

    initial begin
        int nv;
        logic [2:0] ra;
        areset      = 1'b1;
        req_valid   = 1'b0;
        req_addr    = '0;
        resp_ready  = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
        mem[5] = 8'hA3;
        mem[2] = 8'h5C;
        for (int i = 0; i < L; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
            pc[i] = '0;
        end
        repeat (3) step();
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_rden", rden, 0);
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_coll_count", coll_count, 0);
        areset = 1'b0;

        run_txn(3'd5, 0);
        plan = '{2'b10, 2'b00};
        run_txn(3'd5, 0);
        plan = '{2'b10, 2'b10, 2'b10, 2'b10};
        run_txn(3'd3, 0);
        plan = '{2'b01};
        run_txn(3'd2, 0);
        run_txn(3'd4, 5);

        for (int t = 0; t < 40; t++) begin
            nv = $urandom_range(0, 5);
            for (int k = 0; k < nv; k++) plan.push_back(2'($urandom));
            ra = 3'($urandom);
            run_txn(ra, $urandom_range(0, 3));
        end

        // Reset in the middle of WAIT drops the request silently.
        plan = '{2'b10, 2'b10};
        req_addr  = 3'd6;
        req_valid = 1'b1;
        nv = 0;
        while (!req_ready && nv < 50) begin
            step();
            nv++;
        end
        check_eq("rst_test_accept", req_ready, 1);
        step();
        req_valid = 1'b0;
        step();
        areset = 1'b1;
        #1;
        check_eq("async_rden", rden, 0);
        check_eq("async_rdaddr", rdaddr, 0);
        check_eq("async_req_ready", req_ready, 0);
        check_eq("async_resp_valid", resp_valid, 0);
        check_eq("async_resp_data", resp_data, 0);
        check_eq("async_resp_err", resp_err, 0);
        check_eq("async_resp_wrcoll", resp_wrcoll, 0);
        check_eq("async_coll_count", coll_count, 0);
        step();
        areset = 1'b0;
        plan.delete();
        exp_coll = 0;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (resp_valid || rden) nv++;
        end
        check_eq("no_resp_after_rst", nv, 0);
        run_txn(3'd6, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
